// File: rtl/rs232_rx_fifo.sv
// rs232_rx_fifo: receive-side byte FIFO between the RS-232 receiver and the I/O bus.
// Drains the receiver one byte per handshake, buffers up to 2^DEPTH_LOG2 bytes,
// and records a sticky overrun flag when a byte arrives while the buffer is full.
module rs232_rx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxrdy,
    input  logic [7:0]            rxdata,
    output logic                  rxdone,
    input  logic                  pop,
    input  logic                  clrovf,
    output logic [7:0]            dout,
    output logic                  rdy,
    output logic                  full,
    output logic                  ovf,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;

    logic take;
    logic pop_eff;
    logic push;
    logic drop;

    // Status compares on the occupancy counter
    assign rdy  = (count != '0);
    assign full = (count == CW'(DEPTH));

    // Show-ahead head entry
    assign dout = mem[rp];

    // Handshake and push/pop/drop decisions; ~rxdone blocks a double capture
    always_comb begin
        take    = rxrdy & ~rxdone;
        pop_eff = pop & rdy;
        push    = take & (~full | pop_eff);
        drop    = take & full & ~pop_eff;
    end

    // Storage array, intentionally not reset
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wp] <= rxdata;
        end
    end

    // Pointers, occupancy, acknowledge and sticky overrun flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wp     <= '0;
            rp     <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            rxdone <= 1'b0;
        end else begin
            rxdone <= take;
            if (push) begin
                wp <= wp + PW'(1);
            end
            if (pop_eff) begin
                rp <= rp + PW'(1);
            end
            case ({push, pop_eff})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear leaves the flag set
            if (drop) begin
                ovf <= 1'b1;
            end else if (clrovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rs232_rx_fifo.sv
// tb_rs232_rx_fifo: directed self-checking bench for rs232_rx_fifo (16 entries).
module tb_rs232_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxrdy;
    logic [7:0] rxdata;
    logic       rxdone;
    logic       pop;
    logic       clrovf;
    logic [7:0] dout;
    logic       rdy;
    logic       full;
    logic       ovf;
    logic [4:0] count;

    int tests = 0;
    int fails = 0;

    rs232_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .rxrdy  (rxrdy),
        .rxdata (rxdata),
        .rxdone (rxdone),
        .pop    (pop),
        .clrovf (clrovf),
        .dout   (dout),
        .rdy    (rdy),
        .full   (full),
        .ovf    (ovf),
        .count  (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Receiver model: present a byte, expect a one-cycle rxdone, drop rxrdy after it
    task automatic send(input logic [7:0] d, input logic with_pop, input logic with_clr);
        rxdata = d;
        rxrdy  = 1'b1;
        pop    = with_pop;
        clrovf = with_clr;
        tick();
        pop    = 1'b0;
        clrovf = 1'b0;
        check("rxdone_hi", 32'(rxdone), 32'd1);
        tick();
        check("rxdone_lo", 32'(rxdone), 32'd0);
        rxrdy = 1'b0;
    endtask

    // Core read: sample the head in the strobe cycle, then advance
    task automatic read(input logic [7:0] exp);
        check("dout", 32'(dout), 32'(exp));
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic pulse_clr();
        clrovf = 1'b1;
        tick();
        clrovf = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        rxrdy  = 1'b0;
        rxdata = 8'h00;
        pop    = 1'b0;
        clrovf = 1'b0;
        tick();
        tick();
        check("rst_rdy", 32'(rdy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_rxdone", 32'(rxdone), 32'd0);
        rst = 1'b0;
        tick();

        // Single byte round trip
        send(8'h41, 1'b0, 1'b0);
        check("one_count", 32'(count), 32'd1);
        check("one_rdy", 32'(rdy), 32'd1);
        read(8'h41);
        check("one_count0", 32'(count), 32'd0);
        check("one_rdy0", 32'(rdy), 32'd0);

        // Fill, overrun, drain in order
        for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 1'b0);
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd16);
        check("fill_ovf", 32'(ovf), 32'd0);
        send(8'hAA, 1'b0, 1'b0);
        check("drop_ovf", 32'(ovf), 32'd1);
        check("drop_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) read(8'(i));
        check("drain_count", 32'(count), 32'd0);
        check("drain_full", 32'(full), 32'd0);
        pulse_clr();
        check("clr_ovf", 32'(ovf), 32'd0);

        // Full with simultaneous push and pop: no overrun, pointer wrap
        for (int i = 0; i < 16; i++) send(8'(8'h10 + i), 1'b0, 1'b0);
        send(8'h55, 1'b1, 1'b0);
        check("pp_count", 32'(count), 32'd16);
        check("pp_ovf", 32'(ovf), 32'd0);
        for (int i = 1; i < 16; i++) read(8'(8'h10 + i));
        read(8'h55);
        check("pp_empty", 32'(count), 32'd0);

        // Pop while empty is ignored
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("epop_count", 32'(count), 32'd0);
        check("epop_rdy", 32'(rdy), 32'd0);
        check("epop_ovf", 32'(ovf), 32'd0);
        send(8'h33, 1'b0, 1'b0);
        check("epop_cnt1", 32'(count), 32'd1);
        read(8'h33);

        // Empty with take and pop together: byte pushed, pop ignored
        send(8'h3C, 1'b1, 1'b0);
        check("etp_count", 32'(count), 32'd1);
        read(8'h3C);

        // Drop and clear in the same cycle: set wins
        for (int i = 0; i < 16; i++) send(8'(8'h60 + i), 1'b0, 1'b0);
        send(8'h77, 1'b0, 1'b1);
        check("dropclr_ovf", 32'(ovf), 32'd1);
        pulse_clr();
        check("lone_clr_ovf", 32'(ovf), 32'd0);
        check("dropclr_count", 32'(count), 32'd16);
        send(8'h88, 1'b0, 1'b0);
        check("drop2_ovf", 32'(ovf), 32'd1);
        for (int i = 0; i < 11; i++) read(8'(8'h60 + i));
        check("five_count", 32'(count), 32'd5);

        // Reset with data buffered and a byte pending
        rxdata = 8'hC5;
        rxrdy  = 1'b1;
        rst    = 1'b1;
        tick();
        check("mrst_count", 32'(count), 32'd0);
        check("mrst_rdy", 32'(rdy), 32'd0);
        check("mrst_full", 32'(full), 32'd0);
        check("mrst_ovf", 32'(ovf), 32'd0);
        check("mrst_rxdone", 32'(rxdone), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rxdone", 32'(rxdone), 32'd1);
        check("post_count", 32'(count), 32'd1);
        check("post_dout", 32'(dout), 32'hC5);
        tick();
        rxrdy = 1'b0;
        check("post_rxdone0", 32'(rxdone), 32'd0);
        check("post_count1", 32'(count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
